// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word-addressed memory target with req/ack handshake
module mem_responder #(
    parameter int ADDR_BITS = 9,
    parameter int READ_LAT  = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int          DEPTH    = 2 ** ADDR_BITS;
    localparam logic [3:0]  CNT_INIT = 4'(READ_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic [31:0] mem [DEPTH];
    logic [31:0] mem_rd;
    logic        in_range;
    logic        commit;

    assign mem_rd   = mem[addr_q[ADDR_BITS-1:0]];
    assign in_range = (addr_q[31:ADDR_BITS] == '0);
    assign commit   = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = busy_q;

    // Next-state logic: accept in IDLE, count down in WAIT, one-cycle ack in RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_INIT;
                    addr_d  = addr;
                    wdata_d = wdata;
                    wr_d    = wr;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    err_d   = !in_range;
                    // Out-of-range reads return zero; writes leave rdata alone
                    if (!wr_q) begin
                        rdata_d = in_range ? mem_rd : 32'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control and output registers; async reset aborts any transaction in flight
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array: commits in-range writes on the WAIT->RESP edge, never cleared
    always_ff @(posedge clk) begin
        if (clr && commit && wr_q && in_range) begin
            mem[addr_q[ADDR_BITS-1:0]] <= wdata_q;
        end
    end

endmodule
